memorder_sc_ctrl: RTL and testbench



---
 rtl/memorder_sc_pkg.sv | 13 +
 rtl/memorder_store_cnt.sv | 48 ++++
 rtl/memorder_sc_ctrl.sv | 91 +++++++++
 tb/tb_memorder_sc_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/memorder_sc_pkg.sv
// Shared types and defaults for the SC memory-order controller and its LSU assertions.
package memorder_sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } memorder_state_e;

    localparam int unsigned MaxOutstandingStoresDefault = 1;

endpackage

// File: rtl/memorder_store_cnt.sv
// Outstanding committed-store counter: saturating up/down with sticky underflow error.
module memorder_store_cnt #(
    parameter int unsigned MaxCount = 1,
    parameter int unsigned CntWidth = $clog2(MaxCount + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] count_o,
    output logic [CntWidth-1:0] count_next_o,
    output logic                err_o
);

    logic [CntWidth-1:0] count_q, count_d;
    logic                err_q, err_d;
    logic                dec_ok;
    logic                at_max;

    // Next count; an ack at zero is dropped and flagged instead of wrapping.
    always_comb begin
        count_d = count_q;
        dec_ok  = dec_i && (count_q != '0);
        at_max  = (count_q == CntWidth'(MaxCount));
        err_d   = err_q || (dec_i && (count_q == '0));
        if (inc_i && !dec_ok && !at_max) begin
            count_d = count_q + CntWidth'(1);
        end else if (!inc_i && dec_ok) begin
            count_d = count_q - CntWidth'(1);
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign err_o        = err_q;

endmodule

// File: rtl/memorder_sc_ctrl.sv
// SC memory-order controller: store cap, load hold-off until stores drain, fence sequencing.
module memorder_sc_ctrl
    import memorder_sc_pkg::*;
#(
    parameter int unsigned MaxOutstandingStores = MaxOutstandingStoresDefault,
    parameter bit          FlushOnFence         = 1'b1,
    parameter int unsigned CntWidth             = $clog2(MaxOutstandingStores + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                st_req_i,
    output logic                st_gnt_o,
    input  logic                st_ack_i,
    input  logic                ld_req_i,
    output logic                ld_gnt_o,
    input  logic                fence_req_i,
    output logic                fence_ack_o,
    output logic                dcache_flush_o,
    input  logic                dcache_flush_ack_i,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                busy_o,
    output logic                proto_err_o
);

    memorder_state_e     state_q, state_d;
    logic                dcache_flush_q, dcache_flush_d;
    logic                fence_ack_q, fence_ack_d;
    logic                busy_q, busy_d;
    logic [CntWidth-1:0] count;
    logic [CntWidth-1:0] count_next;
    logic                grant_window;
    logic                max_reached;

    // Grants are zero-latency; a store may take the slot freed by a same-cycle ack.
    always_comb begin
        grant_window = (state_q == IDLE) && !fence_req_i;
        max_reached  = (count == CntWidth'(MaxOutstandingStores));
        st_gnt_o     = st_req_i && grant_window && (!max_reached || st_ack_i);
        ld_gnt_o     = ld_req_i && grant_window && (count == '0) && !st_req_i && !flush_i;
    end

    memorder_store_cnt #(
        .MaxCount (MaxOutstandingStores),
        .CntWidth (CntWidth)
    ) u_store_cnt (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .inc_i        (st_gnt_o),
        .dec_i        (st_ack_i),
        .count_o      (count),
        .count_next_o (count_next),
        .err_o        (proto_err_o)
    );

    // Fence sequencing; drain completes on the cycle whose ack empties the counter.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (fence_req_i) state_d = DRAIN;
            DRAIN: if (count_next == '0) state_d = FlushOnFence ? FLUSH : DONE;
            FLUSH: if (dcache_flush_ack_i) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        dcache_flush_d = (state_d == FLUSH);
        fence_ack_d    = (state_d == DONE);
        busy_d         = (count_next != '0) || (state_d != IDLE);
    end

    // State and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            dcache_flush_q <= 1'b0;
            fence_ack_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            dcache_flush_q <= dcache_flush_d;
            fence_ack_q    <= fence_ack_d;
            busy_q         <= busy_d;
        end
    end

    assign dcache_flush_o = dcache_flush_q;
    assign fence_ack_o    = fence_ack_q;
    assign busy_o         = busy_q;
    assign outstanding_o  = count;

endmodule

// File: tb/tb_memorder_sc_ctrl.sv
// Bench for memorder_sc_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_memorder_sc_ctrl;

    localparam logic [5:0] SR = 6'b100000;  // st_req
    localparam logic [5:0] SA = 6'b010000;  // st_ack
    localparam logic [5:0] LR = 6'b001000;  // ld_req
    localparam logic [5:0] FN = 6'b000100;  // fence_req
    localparam logic [5:0] FL = 6'b000010;  // pipeline flush
    localparam logic [5:0] FA = 6'b000001;  // dcache flush ack

    localparam int S_IDLE = 0, S_DRAIN = 1, S_FLUSH = 2, S_DONE = 3;

    logic clk;
    logic rst_n;
    logic st_req[2], st_ack[2], ld_req[2], fence[2], pflush[2], fack[2];
    logic st_gnt[2], ld_gnt[2], fence_ack[2], dflush[2], busy[2], perr[2];
    logic [0:0] outst0;
    logic [1:0] outst1;

    int checks = 0;
    int errors = 0;

    int m_cnt[2];
    int m_st[2];
    bit m_err[2];
    int m_max[2] = '{1, 3};
    bit m_fl[2]  = '{1'b1, 1'b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    memorder_sc_ctrl #(.MaxOutstandingStores(1), .FlushOnFence(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(pflush[0]),
        .st_req_i(st_req[0]), .st_gnt_o(st_gnt[0]), .st_ack_i(st_ack[0]),
        .ld_req_i(ld_req[0]), .ld_gnt_o(ld_gnt[0]),
        .fence_req_i(fence[0]), .fence_ack_o(fence_ack[0]),
        .dcache_flush_o(dflush[0]), .dcache_flush_ack_i(fack[0]),
        .outstanding_o(outst0), .busy_o(busy[0]), .proto_err_o(perr[0])
    );

    memorder_sc_ctrl #(.MaxOutstandingStores(3), .FlushOnFence(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(pflush[1]),
        .st_req_i(st_req[1]), .st_gnt_o(st_gnt[1]), .st_ack_i(st_ack[1]),
        .ld_req_i(ld_req[1]), .ld_gnt_o(ld_gnt[1]),
        .fence_req_i(fence[1]), .fence_ack_o(fence_ack[1]),
        .dcache_flush_o(dflush[1]), .dcache_flush_ack_i(fack[1]),
        .outstanding_o(outst1), .busy_o(busy[1]), .proto_err_o(perr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outst(input int d);
        return (d == 0) ? 32'(outst0) : 32'(outst1);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0;
            m_st[d]  = S_IDLE;
            m_err[d] = 1'b0;
        end
    endtask

    // Compare one instance against the model for the current cycle, then advance the model.
    task automatic model_step(input int d);
        bit idle, eg_st, eg_ld;
        int nc;
        idle  = (m_st[d] == S_IDLE);
        eg_st = st_req[d] && idle && !fence[d] && ((m_cnt[d] < m_max[d]) || st_ack[d]);
        eg_ld = ld_req[d] && idle && !fence[d] && (m_cnt[d] == 0) && !st_req[d] && !pflush[d];
        chk($sformatf("d%0d st_gnt", d), 32'(st_gnt[d]), 32'(eg_st));
        chk($sformatf("d%0d ld_gnt", d), 32'(ld_gnt[d]), 32'(eg_ld));
        chk($sformatf("d%0d outstanding", d), outst(d), 32'(m_cnt[d]));
        chk($sformatf("d%0d fence_ack", d), 32'(fence_ack[d]), 32'(m_st[d] == S_DONE));
        chk($sformatf("d%0d dcache_flush", d), 32'(dflush[d]), 32'(m_st[d] == S_FLUSH));
        chk($sformatf("d%0d busy", d), 32'(busy[d]), 32'((m_cnt[d] != 0) || !idle));
        chk($sformatf("d%0d proto_err", d), 32'(perr[d]), 32'(m_err[d]));
        if (st_ack[d] && m_cnt[d] == 0) m_err[d] = 1'b1;
        nc = m_cnt[d] + int'(eg_st) - ((st_ack[d] && m_cnt[d] > 0) ? 1 : 0);
        case (m_st[d])
            S_IDLE:  if (fence[d]) m_st[d] = S_DRAIN;
            S_DRAIN: if (nc == 0) m_st[d] = m_fl[d] ? S_FLUSH : S_DONE;
            S_FLUSH: if (fack[d]) m_st[d] = S_DONE;
            default: m_st[d] = S_IDLE;
        endcase
        m_cnt[d] = nc;
    endtask

    // Drive one cycle of inputs for both instances and check them before the next rising edge.
    task automatic apply(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] v[2];
        v[0] = a;
        v[1] = b;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            st_req[d] = v[d][5];
            st_ack[d] = v[d][4];
            ld_req[d] = v[d][3];
            fence[d]  = v[d][2];
            pflush[d] = v[d][1];
            fack[d]   = v[d][0];
        end
        #1;
        model_step(0);
        model_step(1);
    endtask

    initial begin
        logic [5:0] rv[2];
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st_req[d] = 0; st_ack[d] = 0; ld_req[d] = 0;
            fence[d] = 0; pflush[d] = 0; fack[d] = 0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst st_gnt", 32'(st_gnt[d]), 32'd0);
            chk("rst ld_gnt", 32'(ld_gnt[d]), 32'd0);
            chk("rst fence_ack", 32'(fence_ack[d]), 32'd0);
            chk("rst dcache_flush", 32'(dflush[d]), 32'd0);
            chk("rst outstanding", outst(d), 32'd0);
            chk("rst busy", 32'(busy[d]), 32'd0);
            chk("rst proto_err", 32'(perr[d]), 32'd0);
        end
        rst_n = 1'b1;

        // Max=1 store cap with a same-cycle ack freeing the slot
        apply(SR, 0);      chk("cap c0 gnt", 32'(st_gnt[0]), 32'd1);
        apply(SR, 0);      chk("cap c1 gnt", 32'(st_gnt[0]), 32'd0); chk("cap c1 cnt", outst(0), 32'd1);
        apply(SR | SA, 0); chk("cap c2 gnt", 32'(st_gnt[0]), 32'd1); chk("cap c2 cnt", outst(0), 32'd1);
        apply(0, 0);       chk("cap c3 cnt", outst(0), 32'd1);
        apply(SA, 0);

        // Loads wait for the store to drain; a store in the same cycle wins
        apply(SR, 0);
        for (int i = 1; i <= 3; i++) begin
            apply(LR, 0);  chk("ld hold", 32'(ld_gnt[0]), 32'd0);
        end
        apply(LR | SA, 0); chk("ld ack cycle", 32'(ld_gnt[0]), 32'd0);
        apply(LR | SR, 0); chk("ld prio st", 32'(st_gnt[0]), 32'd1); chk("ld prio ld", 32'(ld_gnt[0]), 32'd0);
        apply(LR | SA, 0); chk("ld wait2", 32'(ld_gnt[0]), 32'd0);
        apply(LR | FL, 0); chk("ld pipeflush", 32'(ld_gnt[0]), 32'd0);
        apply(LR, 0);      chk("ld go", 32'(ld_gnt[0]), 32'd1);

        // Fence with one store outstanding, ack in cycle 3, flush ack two cycles after flush rises
        apply(SR, 0);
        apply(FN | SR | LR, 0);
        chk("fence c0 st", 32'(st_gnt[0]), 32'd0); chk("fence c0 ld", 32'(ld_gnt[0]), 32'd0);
        for (int i = 1; i <= 7; i++) begin
            apply(SR | LR | ((i == 3) ? SA : 6'b0) | ((i == 6) ? FA : 6'b0), 0);
            chk($sformatf("fence c%0d st", i), 32'(st_gnt[0]), 32'd0);
            chk($sformatf("fence c%0d ld", i), 32'(ld_gnt[0]), 32'd0);
            chk($sformatf("fence c%0d ack", i), 32'(fence_ack[0]), 32'(i == 7));
            if (i == 4) chk("fence flush rise", 32'(dflush[0]), 32'd1);
        end
        apply(SR, 0); chk("fence after st", 32'(st_gnt[0]), 32'd1); chk("fence after ack", 32'(fence_ack[0]), 32'd0);
        apply(SA, 0);

        // No-flush configuration, fence with empty counter
        apply(0, FN); chk("nf c0 flush", 32'(dflush[1]), 32'd0);
        apply(0, 0);  chk("nf c1 flush", 32'(dflush[1]), 32'd0); chk("nf c1 ack", 32'(fence_ack[1]), 32'd0);
        apply(0, 0);  chk("nf c2 flush", 32'(dflush[1]), 32'd0); chk("nf c2 ack", 32'(fence_ack[1]), 32'd1);
        apply(0, 0);  chk("nf c3 ack", 32'(fence_ack[1]), 32'd0);

        // Ack with nothing outstanding
        apply(SA, 0);
        apply(0, 0); chk("perr set", 32'(perr[0]), 32'd1); chk("perr cnt", outst(0), 32'd0);
        apply(0, 0); chk("perr sticky", 32'(perr[0]), 32'd1);

        // Reset while flushing
        apply(FN, 0);
        apply(0, 0);
        apply(0, 0); chk("rstf flush on", 32'(dflush[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstf flush off", 32'(dflush[0]), 32'd0);
        chk("rstf busy", 32'(busy[0]), 32'd0);
        chk("rstf cnt", outst(0), 32'd0);
        chk("rstf perr", 32'(perr[0]), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply(FN, 0);
        apply(0, 0);
        apply(FA, 0); chk("refence flush", 32'(dflush[0]), 32'd1);
        apply(0, 0);  chk("refence ack", 32'(fence_ack[0]), 32'd1);

        // Random traffic on both instances
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 2; d++) begin
                rv[d] = '0;
                if ($urandom_range(0, 1) == 1) rv[d] |= SR;
                if (m_cnt[d] > 0 && $urandom_range(0, 2) == 0) rv[d] |= SA;
                if ($urandom_range(0, 1) == 1) rv[d] |= LR;
                if ($urandom_range(0, 9) == 0) rv[d] |= FN;
                if ($urandom_range(0, 3) == 0) rv[d] |= FL;
                if ($urandom_range(0, 2) == 0) rv[d] |= FA;
            end
            apply(rv[0], rv[1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
